// File: rtl/id_ex_stage_pkg.sv
// Shared decode/ID-EX definitions: control bundle layout, opcodes,
// ALUOp encodings and the ID/EX register bundle.
package id_ex_stage_pkg;

  localparam int CTRL_W        = 8;
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_ALUOP_HI = 2;
  localparam int CTRL_ALUOP_LO = 1;
  localparam int CTRL_REGDST   = 0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_IMM   = 2'b10;
  localparam logic [1:0] ALUOP_RTYPE = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef logic [4:0]        reg_t;
  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    reg_t        rs;
    reg_t        rt;
    reg_t        rd;
  } id_ex_t;

  function automatic logic [31:0] signExt16(
    input logic [15:0] v
  );
    return {{16{v[15]}}, v};
  endfunction

  function automatic reg_t dstReg(
    input ctrl_t ctrl,
    input reg_t  rt,
    input reg_t  rd
  );
    return ctrl[CTRL_REGDST] ? rd : rt;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard.sv
// Combinational hazard detection for the ID stage:
// load-use, branch-vs-EX and branch-vs-MEM-load.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic  valid,
  input  ctrl_t ctrl,
  input  logic  branch,
  input  logic  jump,
  input  reg_t  rs,
  input  reg_t  rt,
  input  ctrl_t exCtrl,
  input  reg_t  exRt,
  input  reg_t  exRd,
  input  logic  memMemRead,
  input  reg_t  memRt,
  output logic  stall
);

  logic useRs;
  logic useRt;
  reg_t exDst;
  logic loadUse;
  logic branchEx;
  logic branchMem;

  assign useRs = valid & ~jump;
  assign useRt = valid & (ctrl[CTRL_REGDST]
                        | ctrl[CTRL_MEMWRITE]
                        | branch);

  assign exDst = dstReg(exCtrl, exRt, exRd);

  assign loadUse = exCtrl[CTRL_MEMREAD]
                 & (exRt != 5'd0)
                 & ((useRs & (exRt == rs))
                  | (useRt & (exRt == rt)));

  // beq compares in ID, so any in-flight producer of its operands blocks it
  assign branchEx = valid & branch
                  & exCtrl[CTRL_REGWRITE]
                  & (exDst != 5'd0)
                  & ((exDst == rs) | (exDst == rt));

  assign branchMem = valid & branch
                   & memMemRead
                   & (memRt != 5'd0)
                   & ((memRt == rs) | (memRt == rt));

  assign stall = loadUse | branchEx | branchMem;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard stall, ID-stage beq/j
// resolution and a saturating stall counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [7:0]       ctrl_i,
  input  logic             branch_i,
  input  logic             jump_i,
  input  logic [31:0]      rs_data_i,
  input  logic [31:0]      rt_data_i,
  input  logic [15:0]      imm_i,
  input  logic [4:0]       rs_i,
  input  logic [4:0]       rt_i,
  input  logic [4:0]       rd_i,
  input  logic             mem_memread_i,
  input  logic [4:0]       mem_rt_i,
  output logic [7:0]       ex_ctrl_o,
  output logic [31:0]      ex_rs_data_o,
  output logic [31:0]      ex_rt_data_o,
  output logic [31:0]      ex_imm_o,
  output logic [4:0]       ex_rs_o,
  output logic [4:0]       ex_rt_o,
  output logic [4:0]       ex_rd_o,
  output logic             stall_o,
  output logic             branch_taken_o,
  output logic             ifid_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  id_ex_t          exReg;
  id_ex_t          exNext;
  logic            bubble;
  logic            operandsEq;
  logic [CNT_W-1:0] stallCnt;

  hazard_detect uHazard (
    .valid      (valid_i),
    .ctrl       (ctrl_i),
    .branch     (branch_i),
    .jump       (jump_i),
    .rs         (rs_i),
    .rt         (rt_i),
    .exCtrl     (exReg.ctrl),
    .exRt       (exReg.rt),
    .exRd       (exReg.rd),
    .memMemRead (mem_memread_i),
    .memRt      (mem_rt_i),
    .stall      (stall_o)
  );

  assign operandsEq = (rs_data_i == rt_data_i);

  assign branch_taken_o = valid_i & branch_i
                        & ~stall_o & operandsEq;

  assign ifid_flush_o = branch_taken_o
                      | (valid_i & jump_i & ~stall_o);

  assign bubble = stall_o | ~valid_i;

  // Only control is zeroed on a bubble; operands are don't-care then
  always_comb begin
    exNext        = '0;
    exNext.ctrl   = bubble ? '0 : ctrl_i;
    exNext.rsData = rs_data_i;
    exNext.rtData = rt_data_i;
    exNext.imm    = signExt16(imm_i);
    exNext.rs     = rs_i;
    exNext.rt     = rt_i;
    exNext.rd     = rd_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      exReg <= '0;
    end else begin
      exReg <= exNext;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stallCnt <= '0;
    end else if (stall_o && !(&stallCnt)) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign ex_ctrl_o    = exReg.ctrl;
  assign ex_rs_data_o = exReg.rsData;
  assign ex_rt_data_o = exReg.rtData;
  assign ex_imm_o     = exReg.imm;
  assign ex_rs_o      = exReg.rs;
  assign ex_rt_o      = exReg.rt;
  assign ex_rd_o      = exReg.rd;
  assign stall_cnt_o  = stallCnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage.
`timescale 1ns/1ps
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [7:0]  ctrl;
    logic        br;
    logic        jmp;
    logic [31:0] rsD;
    logic [31:0] rtD;
    logic [15:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } vec_t;

  typedef struct packed {
    logic        stall;
    logic        taken;
    logic        flush;
    logic [7:0]  ctrl;
    logic [31:0] rsD;
    logic [31:0] rtD;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 0;
  logic        rstN = 0;
  logic        valid = 0;
  logic [7:0]  ctrl = 0;
  logic        br = 0;
  logic        jmp = 0;
  logic [31:0] rsD = 0;
  logic [31:0] rtD = 0;
  logic [15:0] imm = 0;
  logic [4:0]  rs = 0;
  logic [4:0]  rt = 0;
  logic [4:0]  rd = 0;
  logic        memRd = 0;
  logic [4:0]  memRt = 0;
  logic [7:0]  exCtrl;
  logic [31:0] exRsD;
  logic [31:0] exRtD;
  logic [31:0] exImm;
  logic [4:0]  exRs;
  logic [4:0]  exRt;
  logic [4:0]  exRd;
  logic        stall;
  logic        taken;
  logic        flush;
  logic [15:0] cnt;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  vec_t prev = '0;
  logic [15:0] cntM = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(16)) dut (
    .clk_i          (clk),
    .rst_i          (rstN),
    .valid_i        (valid),
    .ctrl_i         (ctrl),
    .branch_i       (br),
    .jump_i         (jmp),
    .rs_data_i      (rsD),
    .rt_data_i      (rtD),
    .imm_i          (imm),
    .rs_i           (rs),
    .rt_i           (rt),
    .rd_i           (rd),
    .mem_memread_i  (memRd),
    .mem_rt_i       (memRt),
    .ex_ctrl_o      (exCtrl),
    .ex_rs_data_o   (exRsD),
    .ex_rt_data_o   (exRtD),
    .ex_imm_o       (exImm),
    .ex_rs_o        (exRs),
    .ex_rt_o        (exRt),
    .ex_rd_o        (exRd),
    .stall_o        (stall),
    .branch_taken_o (taken),
    .ifid_flush_o   (flush),
    .stall_cnt_o    (cnt)
  );

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  // Monitor: one expected snapshot per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("stall", 32'(stall), 32'(e.stall));
      chk("taken", 32'(taken), 32'(e.taken));
      chk("flush", 32'(flush), 32'(e.flush));
      chk("exCtrl", 32'(exCtrl), 32'(e.ctrl));
      chk("exRsData", exRsD, e.rsD);
      chk("exRtData", exRtD, e.rtD);
      chk("exImm", exImm, e.imm);
      chk("exRs", 32'(exRs), 32'(e.rs));
      chk("exRt", 32'(exRt), 32'(e.rt));
      chk("exRd", 32'(exRd), 32'(e.rd));
      chk("stallCnt", 32'(cnt), 32'(e.cnt));
    end
  end

  function automatic vec_t R(logic [4:0] s, logic [4:0] t,
                             logic [4:0] d, logic [31:0] a,
                             logic [31:0] b);
    vec_t v = '0;
    v.valid = 1; v.ctrl = 8'h87;
    v.rs = s; v.rt = t; v.rd = d;
    v.rsD = a; v.rtD = b; v.imm = 16'h1820;
    return v;
  endfunction

  function automatic vec_t LW(logic [4:0] s, logic [4:0] t,
                              logic [15:0] i);
    vec_t v = '0;
    v.valid = 1; v.ctrl = 8'hE8;
    v.rs = s; v.rt = t; v.imm = i;
    v.rsD = 32'h0000_0100; v.rtD = 32'h0000_0077;
    return v;
  endfunction

  function automatic vec_t BEQ(logic [4:0] s, logic [4:0] t,
                               logic [31:0] a, logic [31:0] b);
    vec_t v = '0;
    v.valid = 1; v.ctrl = 8'h02; v.br = 1;
    v.rs = s; v.rt = t; v.rsD = a; v.rtD = b;
    v.imm = 16'hFFFC;
    return v;
  endfunction

  function automatic vec_t J();
    vec_t v = '0;
    v.valid = 1; v.jmp = 1; v.imm = 16'h0040;
    return v;
  endfunction

  function automatic vec_t NOP();
    return '0;
  endfunction

  function automatic vec_t INV(vec_t x);
    vec_t v = x;
    v.valid = 0;
    return v;
  endfunction

  task automatic step(input logic r, input vec_t v,
                      input logic s, input logic tk,
                      input logic fl, input logic [7:0] c,
                      input bit push = 1);
    exp_t e;
    rstN = r;
    valid = v.valid; ctrl = v.ctrl; br = v.br; jmp = v.jmp;
    rsD = v.rsD; rtD = v.rtD; imm = v.imm;
    rs = v.rs; rt = v.rt; rd = v.rd;
    e = '0;
    e.stall = s; e.taken = tk; e.flush = fl;
    if (r) begin
      e.ctrl = c;
      e.rsD = prev.rsD; e.rtD = prev.rtD;
      e.imm = {{16{prev.imm[15]}}, prev.imm};
      e.rs = prev.rs; e.rt = prev.rt; e.rd = prev.rd;
      e.cnt = cntM;
    end
    if (push) sb.push_back(e);
    if (!r) begin
      prev = '0;
      cntM = 0;
    end else begin
      prev = v;
      if (s && cntM != 16'hFFFF) cntM++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    step(0, NOP(), 0, 0, 0, 8'h00);
    step(1, R(1, 2, 3, 32'd10, 32'd20), 0, 0, 0, 8'h00);
    step(1, NOP(), 0, 0, 0, 8'h87);
    // load-use on rs
    step(1, LW(1, 2, 16'h8004), 0, 0, 0, 8'h00);
    step(1, R(2, 5, 4, 32'd3, 32'd4), 1, 0, 0, 8'hE8);
    memRd = 1; memRt = 2;
    step(1, R(2, 5, 4, 32'd3, 32'd4), 0, 0, 0, 8'h00);
    memRd = 0; memRt = 0;
    step(1, NOP(), 0, 0, 0, 8'h87);
    // lw feeding a lw base register
    step(1, LW(1, 2, 16'h0000), 0, 0, 0, 8'h00);
    step(1, LW(2, 6, 16'h0004), 1, 0, 0, 8'hE8);
    memRd = 1; memRt = 2;
    step(1, LW(2, 6, 16'h0004), 0, 0, 0, 8'h00);
    memRd = 0; memRt = 0;
    step(1, NOP(), 0, 0, 0, 8'hE8);
    // load to $0 never hazards
    step(1, LW(1, 0, 16'h0000), 0, 0, 0, 8'h00);
    step(1, R(0, 5, 4, 32'd0, 32'd9), 0, 0, 0, 8'hE8);
    step(1, NOP(), 0, 0, 0, 8'h87);
    // beq taken / not taken
    step(1, BEQ(1, 2, 32'h5, 32'h5), 0, 1, 1, 8'h00);
    step(1, BEQ(1, 2, 32'h5, 32'h6), 0, 0, 0, 8'h02);
    step(1, NOP(), 0, 0, 0, 8'h02);
    // lw then dependent beq: two stalls, then resolve
    step(1, LW(1, 2, 16'h0000), 0, 0, 0, 8'h00);
    step(1, BEQ(2, 3, 32'h7, 32'h7), 1, 0, 0, 8'hE8);
    memRd = 1; memRt = 2;
    step(1, BEQ(2, 3, 32'h7, 32'h7), 1, 0, 0, 8'h00);
    memRd = 0; memRt = 0;
    step(1, BEQ(2, 3, 32'h7, 32'h7), 0, 1, 1, 8'h00);
    step(1, NOP(), 0, 0, 0, 8'h02);
    step(1, LW(1, 2, 16'h0000), 0, 0, 0, 8'h00);
    step(1, BEQ(2, 3, 32'h7, 32'h8), 1, 0, 0, 8'hE8);
    memRd = 1; memRt = 2;
    step(1, BEQ(2, 3, 32'h7, 32'h8), 1, 0, 0, 8'h00);
    memRd = 0; memRt = 0;
    step(1, BEQ(2, 3, 32'h7, 32'h8), 0, 0, 0, 8'h00);
    step(1, NOP(), 0, 0, 0, 8'h02);
    // jump
    step(1, J(), 0, 0, 1, 8'h00);
    step(1, NOP(), 0, 0, 0, 8'h00);
    // invalid slot never stalls and bubbles EX
    step(1, LW(1, 2, 16'h0000), 0, 0, 0, 8'h00);
    step(1, INV(R(2, 5, 4, 32'd1, 32'd2)), 0, 0, 0, 8'hE8);
    step(1, NOP(), 0, 0, 0, 8'h00);
    // beq behind an ALU producer in EX
    step(1, R(1, 2, 3, 32'd1, 32'd2), 0, 0, 0, 8'h00);
    step(1, BEQ(3, 4, 32'h1, 32'h1), 1, 0, 0, 8'h87);
    step(1, BEQ(3, 4, 32'h1, 32'h1), 0, 1, 1, 8'h00);
    step(1, NOP(), 0, 0, 0, 8'h02);
    // reset while a load-use stall is pending
    step(1, LW(1, 2, 16'h0000), 0, 0, 0, 8'h00);
    step(0, R(2, 5, 4, 32'd3, 32'd4), 0, 0, 0, 8'h00);
    step(1, NOP(), 0, 0, 0, 8'h00);
    // continuous MEM branch hazard drives the counter to saturation
    memRd = 1; memRt = 2;
    step(1, BEQ(2, 3, 32'h0, 32'h0), 1, 0, 0, 8'h00);
    while (cntM < 16'hFFFE)
      step(1, BEQ(2, 3, 32'h0, 32'h0), 1, 0, 0, 8'h00, 0);
    step(1, BEQ(2, 3, 32'h0, 32'h0), 1, 0, 0, 8'h00);
    step(1, BEQ(2, 3, 32'h0, 32'h0), 1, 0, 0, 8'h00);
    step(1, BEQ(2, 3, 32'h0, 32'h0), 1, 0, 0, 8'h00);
    memRd = 0; memRt = 0;
    step(1, NOP(), 0, 0, 0, 8'h00);
    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
